// File: rtl/trace_stream_serialiser.sv
// Buffers completed pipeline trace records and serialises each one as a 21-word frame.
// Record layout assumed here: bit 640 = pass_through, bits [639:0] = {instruction, addr, if/id/ex/wb data}.
module trace_stream_serialiser #(
    parameter int         DEPTH          = 4,
    parameter bit         DROP_WHEN_FULL = 1'b1,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [640:0]             trace_in,
    input  logic                     trace_in_valid,
    output logic                     trace_in_ready,
    output logic [31:0]              out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic [15:0]              dropped_count,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int AW     = $clog2(DEPTH);
    localparam int CW     = AW + 1;
    localparam int EW     = 8 + 641;
    localparam int LAST_W = 20;

    logic [EW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [4:0]    r_word_idx;
    logic [7:0]    r_seq;
    logic [15:0]   r_dropped;

    logic          w_full;
    logic          w_in_ready;
    logic          w_push;
    logic          w_pop;
    logic          w_drop;
    logic          w_seq_inc;
    logic          w_out_valid;
    logic          w_hs;
    logic [EW-1:0] w_head;
    logic [31:0]   w_word;

    // Fullness uses the registered count only, so a same-cycle pop never rescues a push.
    assign w_full      = (r_count == CW'(DEPTH));
    assign w_in_ready  = DROP_WHEN_FULL ? 1'b1 : !w_full;
    assign w_push      = trace_in_valid && !w_full;
    assign w_drop      = DROP_WHEN_FULL && trace_in_valid && w_full;
    assign w_seq_inc   = trace_in_valid && w_in_ready;
    assign w_out_valid = (r_count != '0);
    assign w_hs        = w_out_valid && out_ready;
    assign w_pop       = w_hs && (r_word_idx == 5'(LAST_W));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_word_idx <= '0;
            r_seq      <= '0;
            r_dropped  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            if (w_hs) begin
                r_word_idx <= (r_word_idx == 5'(LAST_W)) ? 5'd0 : r_word_idx + 5'd1;
            end
            if (w_seq_inc) begin
                r_seq <= r_seq + 8'd1;
            end
            if (w_drop && (r_dropped != 16'hFFFF)) begin
                r_dropped <= r_dropped + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {r_seq, trace_in};
        end
    end

    assign w_head = r_mem[r_rd_ptr];

    always_comb begin
        w_word = {SYNC_BYTE, w_head[648:641], 15'd0, w_head[640]};
        for (int k = 1; k <= LAST_W; k++) begin
            if (r_word_idx == 5'(k)) begin
                w_word = w_head[639 - 32*(k-1) -: 32];
            end
        end
    end

    assign trace_in_ready = w_in_ready;
    assign out_valid      = w_out_valid;
    assign out_data       = w_word;
    assign out_last       = w_out_valid && (r_word_idx == 5'(LAST_W));
    assign dropped_count  = r_dropped;
    assign fifo_level     = r_count;

endmodule

// File: tb/tb_trace_stream_serialiser.sv
// Bench for trace_stream_serialiser: drop-mode instance checked against a queue model,
// backpressure instance checked with a hand-written sequence.
module tb_trace_stream_serialiser;

    localparam int DEPTH = 4;

    typedef struct {
        logic              pt;
        logic [19:0][31:0] pl;   // pl[19] is frame word 1, pl[0] is word 20
    } rec_t;

    typedef struct {
        logic [7:0] seq;
        rec_t       r;
    } ent_t;

    typedef struct {
        logic        valid;
        logic        oready;
        logic [2:0]  exp_level;
        logic [15:0] exp_dropped;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rec_t        cur;
    logic [640:0] d_in;
    logic        d_valid, d_ready, d_ovalid, d_oready, d_last;
    logic [31:0] d_data;
    logic [15:0] d_dropped;
    logic [2:0]  d_level;

    logic [640:0] b_in;
    logic        b_valid, b_ready, b_ovalid, b_oready, b_last;
    logic [31:0] b_data;
    logic [15:0] b_dropped;
    logic [2:0]  b_level;

    assign d_in = {cur.pt, cur.pl};

    trace_stream_serialiser #(.DEPTH(DEPTH), .DROP_WHEN_FULL(1'b1), .SYNC_BYTE(8'hA5)) u_drop (
        .clk(clk), .rst(rst),
        .trace_in(d_in), .trace_in_valid(d_valid), .trace_in_ready(d_ready),
        .out_data(d_data), .out_valid(d_ovalid), .out_ready(d_oready), .out_last(d_last),
        .dropped_count(d_dropped), .fifo_level(d_level)
    );

    trace_stream_serialiser #(.DEPTH(DEPTH), .DROP_WHEN_FULL(1'b0), .SYNC_BYTE(8'hA5)) u_bp (
        .clk(clk), .rst(rst),
        .trace_in(b_in), .trace_in_valid(b_valid), .trace_in_ready(b_ready),
        .out_data(b_data), .out_valid(b_ovalid), .out_ready(b_oready), .out_last(b_last),
        .dropped_count(b_dropped), .fifo_level(b_level)
    );

    int n_vec = 0;
    int n_err = 0;

    ent_t        mq[$];
    int          m_w;
    logic [7:0]  m_seq;
    logic [15:0] m_drop;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic rec_t rand_rec();
        rec_t r;
        for (int k = 0; k < 20; k++) r.pl[k] = $urandom;
        r.pt = 1'($urandom_range(0, 1));
        return r;
    endfunction

    function automatic logic [31:0] exp_word(input ent_t e, input int w);
        if (w == 0) return {8'hA5, e.seq, 15'd0, e.r.pt};
        return e.r.pl[20 - w];
    endfunction

    // Check drop-instance outputs against the model, then advance model and clock together.
    task automatic cyc();
        bit   full;
        ent_t e;
        chk("out_valid", 32'(d_ovalid), 32'(mq.size() != 0));
        chk("fifo_level", 32'(d_level), 32'(mq.size()));
        chk("dropped_count", 32'(d_dropped), 32'(m_drop));
        chk("trace_in_ready", 32'(d_ready), 32'd1);
        chk("out_last", 32'(d_last), 32'(mq.size() != 0 && m_w == 20));
        if (mq.size() != 0) chk("out_data", d_data, exp_word(mq[0], m_w));
        if (rst) begin
            mq.delete();
            m_w = 0; m_seq = 8'd0; m_drop = 16'd0;
        end else begin
            full  = (mq.size() == DEPTH);
            e.seq = m_seq;
            e.r   = cur;
            if (d_valid) begin
                m_seq++;
                if (full && m_drop != 16'hFFFF) m_drop++;
            end
            if (mq.size() != 0 && d_oready) begin
                if (m_w == 20) begin
                    m_w = 0;
                    void'(mq.pop_front());
                end else begin
                    m_w++;
                end
            end
            if (d_valid && !full) mq.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; d_valid = 1'b0; b_valid = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    vec_t tbl[7];
    int   hs;
    int   frames;

    initial begin
        tbl[0] = '{1'b1, 1'b0, 3'd1, 16'd0};
        tbl[1] = '{1'b1, 1'b0, 3'd2, 16'd0};
        tbl[2] = '{1'b1, 1'b0, 3'd3, 16'd0};
        tbl[3] = '{1'b1, 1'b0, 3'd4, 16'd0};
        tbl[4] = '{1'b1, 1'b0, 3'd4, 16'd1};
        tbl[5] = '{1'b1, 1'b0, 3'd4, 16'd2};
        tbl[6] = '{1'b0, 1'b0, 3'd4, 16'd2};

        rst = 1'b1; d_valid = 1'b0; d_oready = 1'b0; b_valid = 1'b0; b_oready = 1'b0;
        cur = rand_rec(); b_in = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete(); m_w = 0; m_seq = 8'd0; m_drop = 16'd0;

        chk("reset_out_valid", 32'(d_ovalid), 32'd0);
        chk("reset_out_last", 32'(d_last), 32'd0);
        chk("reset_level", 32'(d_level), 32'd0);
        chk("reset_dropped", 32'(d_dropped), 32'd0);
        chk("reset_ready", 32'(d_ready), 32'd1);
        chk("reset_bp_ready", 32'(b_ready), 32'd1);

        // Backpressure instance: ready falls after the 4th push, rises after first frame completes.
        b_valid = 1'b1; b_oready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b_in = {1'b0, 640'($urandom)};
            cyc();
            chk("bp_ready_fill", 32'(b_ready), 32'(i < 3));
        end
        cyc();
        chk("bp_level_full", 32'(b_level), 32'd4);
        chk("bp_dropped", 32'(b_dropped), 32'd0);
        chk("bp_hdr_seq0", 32'(b_data[23:16]), 32'd0);
        b_valid = 1'b0; b_oready = 1'b1;
        repeat (20) cyc();
        chk("bp_last_w20", 32'(b_last), 32'd1);
        chk("bp_ready_before_pop", 32'(b_ready), 32'd0);
        cyc();
        chk("bp_ready_after_pop", 32'(b_ready), 32'd1);
        chk("bp_level_after_pop", 32'(b_level), 32'd3);
        chk("bp_hdr_seq1", 32'(b_data[23:16]), 32'd1);
        repeat (63) cyc();
        chk("bp_level_drained", 32'(b_level), 32'd0);
        b_oready = 1'b0;

        // Single record, sink always ready.
        cur.pt = 1'b1;
        cur.pl[19] = 32'h00A00093;
        cur.pl[18] = 32'h0000_0080;
        for (int k = 0; k < 18; k++) cur.pl[k] = 32'h7000_0000 + 32'(k);
        d_valid = 1'b1; d_oready = 1'b1;
        cyc();
        d_valid = 1'b0;
        chk("single_valid_rise", 32'(d_ovalid), 32'd1);
        for (int w = 0; w <= 20; w++) begin
            if (w == 0)      chk("single_hdr", d_data, 32'hA500_0001);
            else if (w == 1) chk("single_w1", d_data, 32'h00A00093);
            else if (w == 2) chk("single_w2", d_data, 32'h0000_0080);
            else             chk("single_wk", d_data, 32'h7000_0000 + 32'(20 - w));
            chk("single_last", 32'(d_last), 32'(w == 20));
            cyc();
        end
        chk("single_level0", 32'(d_level), 32'd0);
        chk("single_valid0", 32'(d_ovalid), 32'd0);

        // Three records back-to-back with a toggling sink.
        do_reset();
        hs = 0; frames = 0;
        for (int i = 0; i < 200 && hs < 63; i++) begin
            d_valid  = (i < 3);
            if (i < 3) cur = rand_rec();
            d_oready = (i % 2 == 0);
            if (d_ovalid && d_oready) begin
                hs++;
                if (d_last) frames++;
            end
            cyc();
        end
        d_valid = 1'b0;
        chk("toggle_words", 32'(hs), 32'd63);
        chk("toggle_frames", 32'(frames), 32'd3);
        chk("toggle_level0", 32'(d_level), 32'd0);

        // Overflow with drop, table-driven.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            cur      = rand_rec();
            d_valid  = tbl[i].valid;
            d_oready = tbl[i].oready;
            cyc();
            chk("tbl_level", 32'(d_level), 32'(tbl[i].exp_level));
            chk("tbl_dropped", 32'(d_dropped), 32'(tbl[i].exp_dropped));
        end
        d_valid = 1'b0; d_oready = 1'b1;
        for (int f = 0; f < 4; f++) begin
            chk("drain_hdr_seq", 32'(d_data[23:16]), 32'(f));
            repeat (21) cyc();
        end
        cur = rand_rec();
        d_valid = 1'b1;
        cyc();
        d_valid = 1'b0;
        chk("post_drop_seq6", d_data, {8'hA5, 8'd6, 15'd0, cur.pt});
        repeat (21) cyc();

        // Full FIFO: pop at word 20 and push in the same cycle -> push dropped.
        do_reset();
        d_oready = 1'b0; d_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cur = rand_rec();
            cyc();
        end
        d_valid = 1'b0; d_oready = 1'b1;
        repeat (20) cyc();
        chk("popfull_last", 32'(d_last), 32'd1);
        cur = rand_rec();
        d_valid = 1'b1;
        cyc();
        d_valid = 1'b0;
        chk("popfull_dropped", 32'(d_dropped), 32'd1);
        chk("popfull_level", 32'(d_level), 32'd3);
        chk("popfull_next_seq", 32'(d_data[23:16]), 32'd1);
        repeat (63) cyc();

        // Reset in the middle of a frame.
        do_reset();
        d_oready = 1'b0; d_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cur = rand_rec();
            cyc();
        end
        d_valid = 1'b0; d_oready = 1'b1;
        repeat (7) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("midrst_valid", 32'(d_ovalid), 32'd0);
        chk("midrst_level", 32'(d_level), 32'd0);
        chk("midrst_dropped", 32'(d_dropped), 32'd0);
        d_oready = 1'b0;
        cur = rand_rec();
        d_valid = 1'b1;
        cyc();
        d_valid = 1'b0;
        chk("midrst_first_hdr", d_data, {8'hA5, 8'd0, 15'd0, cur.pt});
        d_oready = 1'b1;
        repeat (21) cyc();

        // Randomised traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            d_valid = ($urandom_range(0, 2) == 0);
            if (d_valid) cur = rand_rec();
            d_oready = ($urandom_range(0, 3) != 0);
            cyc();
        end
        d_valid = 1'b0; d_oready = 1'b1;
        repeat (100) cyc();
        chk("random_drained", 32'(d_level), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/trace_stream_serialiser.md
Name: trace_stream_serialiser

Overview:
- Sits directly downstream of the pipeline trace tracker. Consumes one completed `trace_output` record per handshake: 641 bits, with `DATA_WIDTH` = `ADDR_WIDTH` = 32.
- Buffers records in a small FIFO and emits each one as a 21-word, 32-bit frame on a valid/ready stream toward the debug/trace sink.
- Tags each frame with a sequence number and counts records lost to overflow, so the host can detect gaps.

Parameters:
- `DEPTH`, 4: record FIFO depth in entries; power of two, ≥ 2.
- `DROP_WHEN_FULL`, 1: 1 = never stall the tracker, drop records when full; 0 = backpressure via `trace_in_ready`.
- `SYNC_BYTE`, 8'hA5: marker placed in header bits [31:24].

Ports:
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `trace_in`  in  641  `ryuki_datatypes::trace_output` record
- `trace_in_valid`  in  1  record present
- `trace_in_ready`  out  1  record accepted when valid && ready
- `out_data`  out  32  frame word
- `out_valid`  out  1  `out_data` valid
- `out_ready`  in  1  sink accepts word
- `out_last`  out  1  high on word 20 (final word of frame)
- `dropped_count`  out  16  records dropped; saturates at 16'hFFFF
- `fifo_level`  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (synchronous, `rst`=1 at a clock edge):
  - count, pointers, word index, sequence counter and `dropped_count` := 0.
  - `out_valid` = 0, `out_last` = 0, `fifo_level` = 0.
  - `trace_in_ready` = 1.
  - Reset mid-frame abandons the partial frame; no trailing words are emitted.
- Entry storage: each entry holds `{seq[7:0], record[640:0]}`.
- Sequence counter (8 bits):
  - Increments on every presented record: `trace_in_valid` && `trace_in_ready`, or a drop.
  - Wraps 255 → 0.
  - The stored seq is the pre-increment value.
- `trace_in_ready`:
  - `DROP_WHEN_FULL`=1: constant 1.
  - `DROP_WHEN_FULL`=0: = !full (registered count == `DEPTH`).
- Drop (`DROP_WHEN_FULL`=1 only): `trace_in_valid` while full (registered count == `DEPTH`).
  - Record discarded and `dropped_count` increments (saturating).
  - Drops even if a pop happens in the same cycle; fullness is judged on the registered count only.
- Push/pop same cycle, not full: both occur, count unchanged.
- Latency: a record pushed at edge N is visible at the FIFO head, with `out_valid`=1, from cycle N+1 when the FIFO was empty.
- Output framing, with word index `w` in 0..20:
  - `out_valid` = (count != 0).
  - `out_data` and `out_last` are a combinational mux of head entry and `w`.
  - `w`=0 header: [31:24] = `SYNC_BYTE`, [23:16] = seq, [15:1] = 0, [0] = `pass_through`.
  - `w`=k, 1..20: payload[639-32*(k-1) -: 32], where payload = `{instruction, addr, if_data, id_data, ex_data, wb_data}` (640 bits, MSB first).
  - So word 1 = instruction, word 2 = addr, word 3 = `if_data.time_start`, …, word 20 = `wb_data.mem_access_res.time_end`.
  - `out_last` = `out_valid` && (`w`==20).
- Output handshake, on `out_valid` && `out_ready`:
  - `w` < 20: `w` increments.
  - `w`==20: `w` := 0 and the head is popped.
  - Frames are back-to-back with no idle cycle if the FIFO is non-empty.
- Stability: while `out_valid` && !`out_ready`, `out_data` and `out_last` hold (head and `w` unchanged).
- Pointers: wrap modulo `DEPTH`.
- `fifo_level`: = registered count.

Test Plan:
- Single record, `out_ready`=1 (instruction=32'h00A00093, addr=32'h0000_0080, `pass_through`=1, all times distinct) -> `out_valid` rises cycle after push; 21 words; header 32'hA500_0001; word1=32'h00A00093; word2=32'h80; `out_last` only on word 20; `fifo_level` returns 0.
- Three records pushed back-to-back, `out_ready` toggled 1,0,1,0 -> 63 words with no duplication or skip; `out_data` stable during stalls; header seqs 0,1,2.
- `DROP_WHEN_FULL`=1, `DEPTH`=4, `out_ready`=0, six records pushed -> `fifo_level`=4, `dropped_count`=2; after draining, headers carry seqs 0..3; next pushed record carries seq 6.
- `DROP_WHEN_FULL`=0, `DEPTH`=4, `out_ready`=0 -> `trace_in_ready` falls after the 4th push; `dropped_count` stays 0; on completion of the first frame `trace_in_ready` rises the next cycle.
- Full FIFO with pop (`w`=20 handshake) and push in the same cycle, `DROP_WHEN_FULL`=1 -> push dropped, `dropped_count`+1, `fifo_level`=3.
- `rst` asserted during word 7 of a frame -> next cycle `out_valid`=0, `fifo_level`=0, `dropped_count`=0; first post-reset frame header seq=0, `w` starts at 0.
